// File: rtl/csr_unit.sv
// Machine-mode CSR responder: read-modify-write of M-mode CSRs, interrupt entry/mret,
// 64-bit mcycle/minstret counters and the trap vector.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_read_i,
  input  logic        csr_write_i,
  input  logic        csr_op_inv_i,
  input  logic        csr_no_cal_i,
  input  logic        csr_zimm_en_i,
  input  logic [31:0] csr_zimm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        mret_i,
  input  logic        instr_retire_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        intr_ok_i,
  input  logic [31:0] epc_i,
  output logic        irq_take_o,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o
);

  localparam logic [31:0] MieMask = 32'h0000_0880;

  logic        mie_q, mpie_q;
  logic [31:0] mie_reg_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic        implemented;
  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] src;
  logic [31:0] wdata;
  logic        wr_en;
  logic        ext_pend;
  logic        tmr_pend;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mip_val     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 7'b0};

  always_comb begin
    implemented = 1'b1;
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      12'h300: csr_rdata_o = mstatus_val;
      12'h301: csr_rdata_o = MISA_VALUE;
      12'h304: csr_rdata_o = mie_reg_q;
      12'h305: csr_rdata_o = mtvec_q;
      12'h340: csr_rdata_o = mscratch_q;
      12'h341: csr_rdata_o = mepc_q;
      12'h342: csr_rdata_o = mcause_q;
      12'h344: csr_rdata_o = mip_val;
      12'hB00: csr_rdata_o = mcycle_q[31:0];
      12'hB80: csr_rdata_o = mcycle_q[63:32];
      12'hB02: csr_rdata_o = minstret_q[31:0];
      12'hB82: csr_rdata_o = minstret_q[63:32];
      12'hF14: csr_rdata_o = HART_ID;
      default: implemented = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_read_i &
                         (~implemented | (csr_write_i & (csr_addr_i[11:10] == 2'b11)));

  assign src = csr_zimm_en_i ? {27'b0, csr_zimm_i[4:0]} : rs1_data_i;

  always_comb begin
    if (csr_no_cal_i) begin
      wdata = src;
    end else if (csr_op_inv_i) begin
      wdata = csr_rdata_o & ~src;
    end else begin
      wdata = csr_rdata_o | src;
    end
  end

  assign ext_pend   = mie_reg_q[11] & irq_ext_i;
  assign tmr_pend   = mie_reg_q[7] & irq_timer_i;
  assign irq_take_o = ~rst_i & mie_q & intr_ok_i & ~mret_i & (ext_pend | tmr_pend);

  // Set/clear with a zero source is a pure read; a taken interrupt squashes the write.
  assign wr_en = csr_read_i & csr_write_i & ~csr_illegal_o & ~irq_take_o &
                 (csr_no_cal_i | (src != 32'h0));

  assign trap_vector_o = mtvec_q;
  assign mepc_o        = mepc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_reg_q  <= 32'h0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
      if (instr_retire_i && !irq_take_o) begin
        minstret_q <= minstret_q + 64'd1;
      end

      // Counter-half writes come after the increments so they replace them.
      if (wr_en) begin
        case (csr_addr_i)
          12'h300: begin
            mie_q  <= wdata[3];
            mpie_q <= wdata[7];
          end
          12'h304: mie_reg_q  <= wdata & MieMask;
          12'h305: mtvec_q    <= {wdata[31:2], 2'b00};
          12'h340: mscratch_q <= wdata;
          12'h341: mepc_q     <= {wdata[31:2], 2'b00};
          12'h342: mcause_q   <= wdata;
          12'hB00: mcycle_q   <= {mcycle_q[63:32], wdata};
          12'hB80: mcycle_q   <= {wdata, mcycle_q[31:0]};
          12'hB02: minstret_q <= {minstret_q[63:32], wdata};
          12'hB82: minstret_q <= {wdata, minstret_q[31:0]};
          default: ;
        endcase
      end

      if (irq_take_o) begin
        mepc_q   <= {epc_i[31:2], 2'b00};
        mcause_q <= ext_pend ? 32'h8000_000B : 32'h8000_0007;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end

      if (mret_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: vector table for reads/RMW/interrupts/illegal accesses,
// hand-written sequences for reset, counters and wrap.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic        csr_read, csr_write, csr_op_inv, csr_no_cal, csr_zimm_en;
  logic [31:0] csr_zimm, rs1_data, csr_rdata;
  logic        csr_illegal;
  logic        mret, instr_retire, irq_ext, irq_timer, intr_ok;
  logic [31:0] epc;
  logic        irq_take;
  logic [31:0] trap_vector, mepc;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .csr_addr_i     (csr_addr),
    .csr_read_i     (csr_read),
    .csr_write_i    (csr_write),
    .csr_op_inv_i   (csr_op_inv),
    .csr_no_cal_i   (csr_no_cal),
    .csr_zimm_en_i  (csr_zimm_en),
    .csr_zimm_i     (csr_zimm),
    .rs1_data_i     (rs1_data),
    .csr_rdata_o    (csr_rdata),
    .csr_illegal_o  (csr_illegal),
    .mret_i         (mret),
    .instr_retire_i (instr_retire),
    .irq_ext_i      (irq_ext),
    .irq_timer_i    (irq_timer),
    .intr_ok_i      (intr_ok),
    .epc_i          (epc),
    .irq_take_o     (irq_take),
    .trap_vector_o  (trap_vector),
    .mepc_o         (mepc)
  );

  typedef enum logic [2:0] {OpNone, OpRd, OpRw, OpRs, OpRc} op_e;

  // ctl packs {mret, irq_ext, irq_timer, intr_ok}
  typedef struct {
    op_e         op;
    logic [11:0] addr;
    logic        zen;
    logic [31:0] src;
    logic [3:0]  ctl;
    logic [31:0] epc;
    logic [31:0] rdata;
    logic        ill;
    logic        take;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(op_e op, logic [11:0] addr, logic zen, logic [31:0] src,
                              logic [3:0] ctl, logic [31:0] e, logic [31:0] rdata,
                              logic ill, logic take);
    vec_t v;
    v.op = op; v.addr = addr; v.zen = zen; v.src = src; v.ctl = ctl; v.epc = e;
    v.rdata = rdata; v.ill = ill; v.take = take;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Unused source path gets junk so a wrong zimm/rs1 select shows up.
  task automatic drive(op_e op, logic [11:0] addr, logic zen, logic [31:0] src,
                       logic [3:0] ctl, logic [31:0] e);
    csr_addr    = addr;
    csr_read    = (op != OpNone);
    csr_write   = (op == OpRw) || (op == OpRs) || (op == OpRc);
    csr_op_inv  = (op == OpRc);
    csr_no_cal  = (op == OpRw);
    csr_zimm_en = zen;
    csr_zimm    = zen ? src : 32'h0000_001F;
    rs1_data    = zen ? 32'hFFFF_FFFF : src;
    {mret, irq_ext, irq_timer, intr_ok} = ctl;
    epc         = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_retire = 1'b0;
    drive(OpNone, 12'h000, 1'b0, 32'h0, 4'b0000, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0000, 32'h0, 32'h0000_1800, 0, 0));
    vecs.push_back(mk(OpRd, 12'h305, 0, 32'h0, 4'b0000, 32'h0, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(OpRd, 12'h301, 0, 32'h0, 4'b0000, 32'h0, 32'h4000_1100, 0, 0));
    vecs.push_back(mk(OpRd, 12'hF14, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(OpRw, 12'h340, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(OpRs, 12'h340, 1, 32'h5, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(OpRc, 12'h340, 0, 32'hFF, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(OpRs, 12'h340, 1, 32'hFFFF_FFE0, 4'b0000, 32'h0, 32'hDEAD_BE00, 0, 0));
    vecs.push_back(mk(OpRd, 12'h340, 0, 32'h0, 4'b0000, 32'h0, 32'hDEAD_BE00, 0, 0));
    vecs.push_back(mk(OpRs, 12'h304, 0, 32'h880, 4'b0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(OpRd, 12'h304, 0, 32'h0, 4'b0000, 32'h0, 32'h880, 0, 0));
    vecs.push_back(mk(OpRs, 12'h300, 1, 32'h8, 4'b0000, 32'h0, 32'h1800, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0000, 32'h0, 32'h1808, 0, 0));
    // Interrupt taken with a same-cycle mscratch write that must be dropped.
    vecs.push_back(mk(OpRw, 12'h340, 0, 32'h1234_5678, 4'b0111, 32'h1236, 32'hDEAD_BE00, 0, 1));
    vecs.push_back(mk(OpRd, 12'h341, 0, 32'h0, 4'b0000, 32'h0, 32'h1234, 0, 0));
    vecs.push_back(mk(OpRd, 12'h342, 0, 32'h0, 4'b0000, 32'h0, 32'h8000_000B, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0000, 32'h0, 32'h1880, 0, 0));
    vecs.push_back(mk(OpRd, 12'h340, 0, 32'h0, 4'b0000, 32'h0, 32'hDEAD_BE00, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b1000, 32'h0, 32'h1880, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0000, 32'h0, 32'h1888, 0, 0));
    vecs.push_back(mk(OpRd, 12'h344, 0, 32'h0, 4'b0100, 32'h0, 32'h800, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b1101, 32'h0, 32'h1888, 0, 0));
    vecs.push_back(mk(OpRd, 12'h344, 0, 32'h0, 4'b0011, 32'h2003, 32'h80, 0, 1));
    vecs.push_back(mk(OpRd, 12'h342, 0, 32'h0, 4'b0000, 32'h0, 32'h8000_0007, 0, 0));
    vecs.push_back(mk(OpRd, 12'h341, 0, 32'h0, 4'b0000, 32'h0, 32'h2000, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0111, 32'h0, 32'h1880, 0, 0));
    // mret beats a same-cycle mstatus write.
    vecs.push_back(mk(OpRw, 12'h300, 0, 32'h0, 4'b1000, 32'h0, 32'h1880, 0, 0));
    vecs.push_back(mk(OpRd, 12'h300, 0, 32'h0, 4'b0000, 32'h0, 32'h1888, 0, 0));
    vecs.push_back(mk(OpRw, 12'hF14, 0, 32'h5, 4'b0000, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(OpRd, 12'hF14, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(OpRd, 12'h7C0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(OpRw, 12'h305, 0, 32'h1237, 4'b0000, 32'h0, 32'h100, 0, 0));
    vecs.push_back(mk(OpRd, 12'h305, 0, 32'h0, 4'b0000, 32'h0, 32'h1234, 0, 0));

    // Reset: illegal follows inputs, irq_take held low.
    rst = 1'b1;
    instr_retire = 1'b0;
    drive(OpRd, 12'h7C0, 1'b0, 32'h0, 4'b0111, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_illegal", 32'(csr_illegal), 32'h1);
    check("reset_irq_take", 32'(irq_take), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(OpRd, 12'hB00, 1'b0, 32'h0, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mcycle_after_reset_%0d", i), csr_rdata, 32'(i));
      @(negedge clk);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].addr, vecs[i].zen, vecs[i].src, vecs[i].ctl, vecs[i].epc);
      #1;
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].rdata);
      check($sformatf("vec%0d_illegal", i), 32'(csr_illegal), 32'(vecs[i].ill));
      check($sformatf("vec%0d_irq_take", i), 32'(irq_take), 32'(vecs[i].take));
    end
    @(negedge clk);
    drive(OpNone, 12'h000, 1'b0, 32'h0, 4'b0000, 32'h0);
    #1;
    check("trap_vector", trap_vector, 32'h1234);
    check("mepc_out", mepc, 32'h2000);

    // minstret counts only retire pulses.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      instr_retire = (i % 2 == 0);
      @(negedge clk);
    end
    instr_retire = 1'b0;
    drive(OpRd, 12'hB02, 1'b0, 32'h0, 4'b0000, 32'h0);
    #1;
    check("minstret_10", csr_rdata, 32'd10);
    csr_addr = 12'hB82;
    #1;
    check("minstreth_0", csr_rdata, 32'h0);

    // mcycle wrap: both halves return to zero on the same edge.
    @(negedge clk);
    drive(OpRw, 12'hB00, 1'b0, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    @(negedge clk);
    drive(OpRw, 12'hB80, 1'b0, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    #1;
    check("mcycleh_before_write", csr_rdata, 32'h0);
    @(negedge clk);
    drive(OpRd, 12'hB00, 1'b0, 32'h0, 4'b0000, 32'h0);
    #1;
    check("mcycle_max_lo", csr_rdata, 32'hFFFF_FFFF);
    csr_addr = 12'hB80;
    #1;
    check("mcycle_max_hi", csr_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    csr_addr = 12'hB00;
    #1;
    check("mcycle_wrap_lo", csr_rdata, 32'h0);
    csr_addr = 12'hB80;
    #1;
    check("mcycle_wrap_hi", csr_rdata, 32'h0);

    // Reset wins over a same-cycle write.
    @(negedge clk);
    drive(OpRw, 12'h340, 1'b0, 32'h1111_1111, 4'b0000, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(OpRw, 12'h340, 1'b0, 32'hAAAA_5555, 4'b0000, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(OpRd, 12'h340, 1'b0, 32'h0, 4'b0000, 32'h0);
    #1;
    check("reset_beats_write", csr_rdata, 32'h0);
    csr_addr = 12'hB00;
    #1;
    check("mcycle_zero_after_reset", csr_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR responder for the ID/EX pipeline. Consumes the CSR command signals produced by instruction decode: address, read/write, set/clear/no-calc, and zimm. It returns the old CSR value for write-back and applies read-modify-write updates. It also owns interrupt entry/exit (mstatus/mepc/mcause), the mcycle/minstret counters, and the trap vector.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0100: mtvec reset value.
- MISA_VALUE, 32'h4000_1100: read-only misa (RV32IM).
- HART_ID, 32'h0: read-only mhartid.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- csr_addr_i  in  12  CSR address.
- csr_read_i  in  1  CSR access.
- csr_write_i  in  1  write request.
- csr_op_inv_i  in  1  clear mode.
- csr_no_cal_i  in  1  write-through mode.
- csr_zimm_en_i  in  1  source is zimm.
- csr_zimm_i  in  32  zimm; only [4:0] used, zero-extended.
- rs1_data_i  in  32  register source operand.
- csr_rdata_o  out  32  current (old) value of the addressed CSR.
- csr_illegal_o  out  1  access to an unimplemented address, or a write to read-only.
- mret_i  in  1  mret executing.
- instr_retire_i  in  1  one instruction retires this cycle.
- irq_ext_i  in  1  external interrupt level.
- irq_timer_i  in  1  timer interrupt level.
- intr_ok_i  in  1  pipeline can accept an interrupt this cycle.
- epc_i  in  32  PC saved on interrupt.
- irq_take_o  out  1  interrupt taken this cycle.
- trap_vector_o  out  32  mtvec.
- mepc_o  out  32  mepc, the mret target.

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11; other bits 0.
  - misa 0x301: read-only.
  - mie 0x304: MEIE[11], MTIE[7].
  - mtvec 0x305: [1:0] hardwired 0, direct mode.
  - mscratch 0x340.
  - mepc 0x341: [1:0] hardwired 0.
  - mcause 0x342.
  - mip 0x344: read-only; MEIP[11]=irq_ext_i, MTIP[7]=irq_timer_i.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14: read-only.
- **Read:** csr_rdata_o is combinational from current state; 0 for unimplemented addresses.
- **Illegal:** csr_illegal_o=1 when csr_read_i=1 and either the address is unimplemented, or csr_write_i=1 and addr[11:10]==2'b11. An illegal access updates no state.
- **Write value:** src = csr_zimm_en_i ? {27'b0,csr_zimm_i[4:0]} : rs1_data_i.
  - no_cal: new = src.
  - op_inv: new = old & ~src.
  - otherwise: new = old | src.
- **Set/clear with src==0:** no write occurs, and counters keep counting.
- **Interrupt request:** irq_take_o = mstatus.MIE & intr_ok_i & ~mret_i & ((MEIE & irq_ext_i) | (MTIE & irq_timer_i)).
- **Interrupt entry** (on irq_take_o), at the next edge:
  - mepc <= {epc_i[31:2],2'b0}.
  - mcause <= 32'h8000_000B if the external interrupt qualifies, else 32'h8000_0007. External has priority.
  - MPIE <= MIE; MIE <= 0.
- **mret:** MIE <= MPIE; MPIE <= 1.
- **Counters:**
  - mcycle: 64-bit, +1 every non-reset cycle.
  - minstret: 64-bit, +1 when instr_retire_i. An interrupted instruction does not retire.
  - Both wrap 2^64-1 -> 0; the carry from the low half propagates into the high half in the same cycle.
- **Precedence:**
  - irq_take_o drops any same-cycle CSR write.
  - mret overrides a same-cycle mstatus write.
  - A CSR write to a counter half replaces that half, and that counter does not increment that cycle.

## Timing
- Reads are combinational: zero latency, old value.
- Writes and trap/mret effects are visible on csr_rdata_o, trap_vector_o and mepc_o in the cycle after the edge.
- irq_take_o is combinational from the current inputs.
- Reset values:
  - mstatus 32'h0000_1800.
  - mie, mscratch, mepc, mcause, mcycle, minstret: 0.
  - mtvec: MTVEC_RESET with [1:0]=0.
- Output values during reset: irq_take_o=0; csr_illegal_o follows its inputs.
- Reset asserted mid-operation wins over every write, trap and increment in that cycle.
- Counters read 0 in the first cycle after reset, then 1 in the next.

## Test plan
- **Reset defaults:** after reset, read 0x300 -> 0x0000_1800; 0x305 -> MTVEC_RESET; 0x301 -> 0x4000_1100; 0xB00 increments 0,1,2 on consecutive cycles.
- **Read-modify-write:** csrrw 0x340 with rs1=0xDEADBEEF, then csrrs with zimm=5 -> rdata 0xDEADBEEF, new 0xDEADBEEF; csrrc with rs1=0xFF -> 0xDEADBE00; csrrs with zimm=0 -> no write.
- **Interrupt entry and return:** MIE=1, MEIE=1, irq_ext_i=1, irq_timer_i=1 (MTIE=1), epc_i=0x1236 -> irq_take_o=1; next cycle mepc=0x1234, mcause=0x8000_000B, mstatus=0x0000_1880. Then mret -> mstatus=0x0000_1888.
- **Interrupt gating:** with irq_take_o high, a same-cycle csrrw to 0x340 is dropped. With intr_ok_i=0 or mret_i=1 -> irq_take_o=0.
- **Illegal accesses:** write to 0xF14 -> csr_illegal_o=1, no change; read 0x7C0 -> illegal, rdata 0.
- **Counter wrap:** write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF -> both halves wrap to 0 together; minstret counts only instr_retire_i pulses (10 pulses over 20 cycles -> 10).
